// File: rtl/prio_enc_hs.sv
// ---------------------------------------------------------------------------
// prio_enc_hs
//
// Priority encoder with a valid/ready output handshake. Pending requests are
// sampled whenever the block is idle or its current grant is being accepted.
// The winning index is then held stable until the consumer takes it. Every
// accepted grant bumps an 8-bit wrapping counter.
//
// Parameters
//   M  number of request lines (M >= 2)
//   N  index width, must equal ceil(log2(M))
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous, active-low reset
//   req[M]      request vector, bit i set = requester i pending
//   out_ready   consumer accepts the presented grant (ignored while idle)
//   out_valid   a grant is presented
//   out_idx[N]  binary index of the grant (holds last value while idle)
//   out_onehot  one-hot form of out_idx, all zero while idle
//   grant_cnt   accepted grants, modulo 256
//
// Build options
//   PRIO_ENC_HS_ROUND_ROBIN_EN  when defined, arbitration is round robin and
//                               the last accepted index gets lowest priority.
//                               When undefined, the highest set index wins.
// ---------------------------------------------------------------------------
module prio_enc_hs #(
  parameter int M = 4,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_idx,
  output logic [M-1:0] out_onehot,
  output logic [7:0]   grant_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         state;
  state_t         next_state;
  logic           load;
  logic           accept;
  logic           req_any;
  logic [N-1:0]   sel_idx;
  logic [M-1:0]   sel_onehot;

  // A load edge samples req: always while idle, or when the held grant is
  // being taken. An accept is a presented grant meeting out_ready.
  assign load      = (state == IDLE) || out_ready;
  assign accept    = (state == HOLD) && out_ready;
  assign req_any   = |req;
  assign out_valid = (state == HOLD);

`ifdef PRIO_ENC_HS_ROUND_ROBIN_EN
  logic [N-1:0] ptr;
  logic [N-1:0] search_ptr;
  int           dist;
  int           best_dist;

  // On an accept edge the pointer is about to move to the accepted index.
  // The simultaneous reload must already use that new pointer, so that
  // back-to-back grants rotate without repeating the winner.
  assign search_ptr = accept ? out_idx : ptr;

  // Each requester gets a distance below the pointer, from 1 up to M. The
  // pointer position itself maps to M, so it is the last choice. The set
  // request with the smallest distance wins.
  always_comb begin
    sel_idx   = '0;
    dist      = 0;
    best_dist = M + 1;
    for (int j = 0; j < M; j++) begin
      dist = int'(search_ptr) - j;
      if (dist <= 0) begin
        dist = dist + M;
      end
      if (req[j] && (dist < best_dist)) begin
        best_dist = dist;
        sel_idx   = N'(j);
      end
    end
  end

  // The round-robin pointer remembers the most recently accepted index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= out_idx;
    end
  end
`else
  // Fixed priority: scanning upward lets the highest set bit overwrite any
  // lower one. Only real request lines are scanned, so the index stays
  // within 0..M-1 even when M is not a power of two.
  always_comb begin
    sel_idx = '0;
    for (int j = 0; j < M; j++) begin
      if (req[j]) begin
        sel_idx = N'(j);
      end
    end
  end
`endif

  // Decode the selected index into one-hot form, ready to be registered
  // together with it.
  always_comb begin
    sel_onehot = '0;
    for (int j = 0; j < M; j++) begin
      sel_onehot[j] = (sel_idx == N'(j));
    end
  end

  // Next state: only a load edge can change state. Whether any request is
  // pending then decides between presenting a grant and going idle.
  always_comb begin
    next_state = state;
    if (load) begin
      next_state = req_any ? HOLD : IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Grant registers. They are frozen while a grant waits for out_ready, so
  // request changes or withdrawals cannot disturb it. When the block goes
  // idle, the one-hot output clears but the binary index keeps its last
  // value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_idx    <= '0;
      out_onehot <= '0;
    end else if (load) begin
      if (req_any) begin
        out_idx    <= sel_idx;
        out_onehot <= sel_onehot;
      end else begin
        out_onehot <= '0;
      end
    end
  end

  // Accepted-grant counter. Reset drops any grant in flight without
  // counting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= 8'd0;
    end else if (accept) begin
      grant_cnt <= grant_cnt + 8'd1;
    end
  end

endmodule
